// File: rtl/ram_bist_pkg.sv
// Shared defaults and FSM encoding for the RAM march-style BIST block.
package ram_bist_pkg;

    localparam int         DEF_ADDR_W = 2;
    localparam int         DEF_DATA_W = 4;
    localparam logic [3:0] DEF_BASE   = 4'hA;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR0  = 3'd1,
        RD0  = 3'd2,
        WR1  = 3'd3,
        RD1  = 3'd4,
        FIN  = 3'd5
    } state_t;

endpackage

// File: rtl/bist_pattern_gen.sv
// Test-pattern generator: phase 0 yields BASE ^ addr, phase 1 its complement.
module bist_pattern_gen
    import ram_bist_pkg::*;
#(
    parameter int                ADDR_W = DEF_ADDR_W,
    parameter int                DATA_W = DEF_DATA_W,
    parameter logic [DATA_W-1:0] BASE   = DATA_W'(DEF_BASE)
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              phase,
    output logic [DATA_W-1:0] pattern
);

    logic [DATA_W-1:0] p0;

    // Address is zero-extended or truncated to the data width before mixing.
    assign p0      = BASE ^ DATA_W'(addr);
    assign pattern = phase ? ~p0 : p0;

endmodule

// File: rtl/ram_bist.sv
// Two-pass RAM BIST (write/read true pattern, then complement) with mismatch logging.
// Define BIST_ERR_COUNT_EN to build the saturating err_count counter; otherwise it reads 0.
module ram_bist
    import ram_bist_pkg::*;
#(
    parameter int                ADDR_W = DEF_ADDR_W,
    parameter int                DATA_W = DEF_DATA_W,
    parameter logic [DATA_W-1:0] BASE   = DATA_W'(DEF_BASE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              SEL,
    output logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] Din,
    input  logic [DATA_W-1:0] Dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [7:0]        err_count,
    output logic [2:0]        state_dbg
);

    localparam int              N        = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(N - 1);
    localparam logic [ADDR_W:0] CNT_N    = (ADDR_W + 1)'(N);

    state_t            state, state_next;
    logic [ADDR_W:0]   cnt, cnt_next;
    logic              run_start, cmp_en, mismatch;
    logic [ADDR_W-1:0] cmp_addr;
    logic [DATA_W-1:0] wr_pattern, cmp_pattern;

    // Read data lags the address by one cycle, so read step i checks address i-1.
    assign cmp_addr  = ADDR_W'(cnt - 1'b1);
    assign mismatch  = cmp_en && (Dout != cmp_pattern);
    assign state_dbg = state;

    bist_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE(BASE)) u_wr_gen (
        .addr    (cnt[ADDR_W-1:0]),
        .phase   (state == WR1),
        .pattern (wr_pattern)
    );

    bist_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE(BASE)) u_cmp_gen (
        .addr    (cmp_addr),
        .phase   (state == RD1),
        .pattern (cmp_pattern)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // start is a single-cycle request with no ready: it is accepted only in
    // IDLE or FIN and silently dropped in every other state.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        SEL        = 1'b0;
        Addr       = '0;
        Din        = '0;
        busy       = 1'b0;
        done       = 1'b0;
        cmp_en     = 1'b0;
        run_start  = 1'b0;
        case (state)
            IDLE, FIN: begin
                done = (state == FIN);
                if (start) begin
                    state_next = WR0;
                    cnt_next   = '0;
                    run_start  = 1'b1;
                end
            end
            WR0, WR1: begin
                busy = 1'b1;
                SEL  = 1'b1;
                Addr = cnt[ADDR_W-1:0];
                Din  = wr_pattern;
                if (cnt == CNT_LAST) begin
                    state_next = (state == WR0) ? RD0 : RD1;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            RD0, RD1: begin
                busy   = 1'b1;
                cmp_en = (cnt != '0);
                if (cnt != CNT_N) begin
                    Addr = cnt[ADDR_W-1:0];
                end
                if (cnt == CNT_N) begin
                    state_next = (state == RD0) ? WR1 : FIN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // pass still high means no mismatch yet, so it marks the first failure.
    always_ff @(posedge clk) begin
        if (reset) begin
            pass      <= 1'b0;
            fail_addr <= '0;
        end else if (run_start) begin
            pass      <= 1'b1;
            fail_addr <= '0;
        end else if (mismatch) begin
            pass <= 1'b0;
            if (pass) begin
                fail_addr <= cmp_addr;
            end
        end
    end

`ifdef BIST_ERR_COUNT_EN
    logic [7:0] err_q;

    always_ff @(posedge clk) begin
        if (reset || run_start) begin
            err_q <= 8'd0;
        end else if (mismatch && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_ram_bist.sv
// Randomized fault-injection bench for ram_bist with a behavioural RAM and expectation model.
module tb_ram_bist;
    import ram_bist_pkg::*;

    localparam int              AW     = 2;
    localparam int              DW     = 4;
    localparam int              N      = 1 << AW;
    localparam int              L      = 4 * N + 2;
    localparam logic [DW-1:0]   BASE_P = 4'hA;
`ifdef BIST_ERR_COUNT_EN
    localparam int              ERR_ON = 1;
`else
    localparam int              ERR_ON = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset, start;
    always #5 clk = ~clk;

    logic          sel, busy, done, pass;
    logic [AW-1:0] addr, fail_addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout = '0;
    logic [7:0]    err_count;
    logic [2:0]    state_dbg;

    ram_bist #(.ADDR_W(AW), .DATA_W(DW), .BASE(BASE_P)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .SEL       (sel),
        .Addr      (addr),
        .Din       (din),
        .Dout      (dout),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .err_count (err_count),
        .state_dbg (state_dbg)
    );

    // ---------------- faulty RAM model ----------------
    logic [DW-1:0] mem [N] = '{default: '0};
    logic [DW-1:0] sa0 [N];
    logic [DW-1:0] sa1 [N];
    logic [AW-1:0] alias_mask;

    function automatic logic [AW-1:0] phys(input logic [AW-1:0] a);
        return a & alias_mask;
    endfunction

    function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] pa, input logic [DW-1:0] v);
        return (v & ~sa0[pa]) | sa1[pa];
    endfunction

    always @(posedge clk) begin
        if (sel) mem[phys(addr)] <= din;
        else     dout <= rd_word(phys(addr), mem[phys(addr)]);
    end

    // ---------------- scoreboard / counters ----------------
    int total = 0;
    int bad   = 0;
    logic chk_on = 1'b0;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int p, input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = BASE_P ^ DW'(a);
        return (p != 0) ? ~v : v;
    endfunction

    // Whole-run outcome: write every word, read every word back, per phase.
    task automatic compute_expect(output logic e_pass, output logic [AW-1:0] e_fail, output int e_err);
        logic [DW-1:0] m [N];
        logic [DW-1:0] r;
        e_pass = 1'b1;
        e_fail = '0;
        e_err  = 0;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < N; a++) m[phys(AW'(a))] = pat(p, AW'(a));
            for (int a = 0; a < N; a++) begin
                r = rd_word(phys(AW'(a)), m[phys(AW'(a))]);
                if (r != pat(p, AW'(a))) begin
                    if (e_pass) e_fail = AW'(a);
                    e_pass = 1'b0;
                    e_err++;
                end
            end
        end
        if (e_err > 255) e_err = 255;
        if (ERR_ON == 0) e_err = 0;
    endtask

    // Model: mk = cycles since the accepted start (0 idle, 1..L busy, L+1 finished).
    int            mk = 0;
    logic          x_pass;
    logic [AW-1:0] x_fail;
    int            x_err;

    always @(posedge clk) begin
        if (reset) mk = 0;
        else if (start && (mk == 0 || mk == L + 1)) begin
            mk = 1;
            compute_expect(x_pass, x_fail, x_err);
        end else if (mk >= 1 && mk <= L) mk = mk + 1;
    end

    // ---------------- per-cycle compare ----------------
    logic          e_sel, e_busy, e_done, c_addr, c_din;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, q_din;

    always @(negedge clk) begin
        if (chk_on) begin
            e_sel = 0; e_busy = 0; e_done = 0; e_addr = '0; e_din = '0; c_addr = 1; c_din = 1;
            if (mk >= 1 && mk <= L) e_busy = 1;
            if (mk >= 1 && mk <= N) begin
                e_sel = 1; e_addr = AW'(mk - 1); e_din = pat(0, AW'(mk - 1));
            end else if (mk >= N + 1 && mk <= 2 * N + 1) begin
                c_din = 0;
                if (mk - N - 1 < N) e_addr = AW'(mk - N - 1); else c_addr = 0;
            end else if (mk >= 2 * N + 2 && mk <= 3 * N + 1) begin
                e_sel = 1; e_addr = AW'(mk - 2 * N - 2); e_din = pat(1, AW'(mk - 2 * N - 2));
            end else if (mk >= 3 * N + 2 && mk <= L) begin
                c_din = 0;
                if (mk - 3 * N - 2 < N) e_addr = AW'(mk - 3 * N - 2); else c_addr = 0;
            end else if (mk == L + 1) e_done = 1;

            check("sel", 32'(sel), 32'(e_sel));
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            if (c_addr) check("addr", 32'(addr), 32'(e_addr));
            if (c_din)  check("din", 32'(din), 32'(e_din));
            if (mk == 0) begin
                check("idle_state", 32'(state_dbg), 32'(IDLE));
                check("idle_pass", 32'(pass), 0);
                check("idle_fail_addr", 32'(fail_addr), 0);
                check("idle_err", 32'(err_count), 0);
            end else if (mk >= 1 && mk <= N) begin
                check("run_pass_cleared", 32'(pass), 1);
                check("run_fail_cleared", 32'(fail_addr), 0);
                check("run_err_cleared", 32'(err_count), 0);
            end else if (mk == L + 1) begin
                check("fin_state", 32'(state_dbg), 32'(FIN));
                check("fin_pass", 32'(pass), 32'(x_pass));
                check("fin_fail_addr", 32'(fail_addr), 32'(x_fail));
                check("fin_err", 32'(err_count), 32'(x_err));
            end
            if (e_sel && exp_q.size() > 0) begin
                q_din = exp_q.pop_front();
                check("din_trace", 32'(din), 32'(q_din));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_faults();
        alias_mask = '1;
        for (int w = 0; w < N; w++) begin
            sa0[w] = '0;
            sa1[w] = '0;
        end
    endtask

    // Pulses start, then follows the run; optional glitch start / mid-run reset at busy cycle k.
    task automatic run_once(input int glitch_at, input int reset_at, output int nb);
        logic fin;
        fin   = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb    = 0;
        for (int g = 0; g < 200; g++) begin
            if (done) begin
                fin = 1;
                break;
            end
            if (busy) nb++;
            start = (glitch_at != 0 && nb == glitch_at);
            if (reset_at != 0 && nb == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                fin   = 1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!fin) check("run_timeout", 0, 1);
    endtask

    int nb;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        clear_faults();
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);

        // Fault-free run with a literal bus trace.
        exp_q = '{4'hA, 4'hB, 4'h8, 4'h9, 4'h5, 4'h4, 4'h7, 4'h6};
        run_once(0, 0, nb);
        check("free_busy_cycles", 32'(nb), 18);
        check("free_trace_used", 32'(exp_q.size()), 0);
        check("free_pass", 32'(pass), 1);
        check("free_err", 32'(err_count), 0);
        check("free_fail_addr", 32'(fail_addr), 0);
        check("model_free_pass", 32'(x_pass), 1);
        repeat (2) @(negedge clk);

        // Bit0 of word 2 stuck at 0.
        sa0[2] = 4'b0001;
        run_once(0, 0, nb);
        check("sa0_pass", 32'(pass), 0);
        check("sa0_fail_addr", 32'(fail_addr), 2);
        check("sa0_err", 32'(err_count), 32'(ERR_ON));
        check("model_sa0_fail", 32'(x_fail), 2);
        clear_faults();

        // Addr[1] ignored by the RAM.
        alias_mask = 2'b01;
        run_once(0, 0, nb);
        check("alias_pass", 32'(pass), 0);
        check("alias_fail_addr", 32'(fail_addr), 0);
        check("alias_err", 32'(err_count), 32'(ERR_ON * 4));
        check("model_alias_err", 32'(x_err), 32'(ERR_ON * 4));
        clear_faults();

        // start during a run is dropped.
        run_once(3, 0, nb);
        check("glitch_busy_cycles", 32'(nb), 18);
        check("glitch_pass", 32'(pass), 1);

        // Reset in the middle of a run, then a clean full run.
        run_once(0, 5, nb);
        check("midreset_state", 32'(state_dbg), 32'(IDLE));
        check("midreset_busy", 32'(busy), 0);
        check("midreset_err", 32'(err_count), 0);
        @(negedge clk);
        run_once(0, 0, nb);
        check("after_reset_busy_cycles", 32'(nb), 18);

        // reset beats start in the same cycle.
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("prio_state", 32'(state_dbg), 32'(IDLE));
        check("prio_busy", 32'(busy), 0);
        @(negedge clk);

        // Randomized fault patterns and start glitches.
        for (int t = 0; t < 8; t++) begin
            case ($urandom_range(0, 3))
                0: alias_mask = 2'b01;
                1: alias_mask = 2'b10;
                default: alias_mask = 2'b11;
            endcase
            for (int w = 0; w < N; w++) begin
                sa0[w] = ($urandom_range(0, 2) == 0) ? DW'($urandom_range(0, 15)) : '0;
                sa1[w] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 15)) : '0;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_once(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 17)) : 0, 0, nb);
            check("rand_busy_cycles", 32'(nb), 18);
        end
        clear_faults();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_bist.md
RAM_BIST -- requirements
Module: ram_bist

Interface
REQ-001 Parameter ADDR_W SHALL be provided, default 2, RAM address width; N = 2**ADDR_W words.
REQ-002 Parameter DATA_W SHALL be provided, default 4, RAM data width.
REQ-003 Parameter BASE SHALL be provided, default 4'hA, DATA_W-bit seed pattern.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to run the test.
REQ-007 SEL  output  1  to RAM: 1 = write, 0 = read.
REQ-008 Addr  output  ADDR_W  to RAM address.
REQ-009 Din  output  DATA_W  to RAM write data.
REQ-010 Dout  input  DATA_W  from RAM: word registered on the edge where SEL=0, valid the following cycle.
REQ-011 busy  output  1  test in progress.
REQ-012 done  output  1  test finished; held until next start or reset.
REQ-013 pass  output  1  no mismatch seen; meaningful while done=1.
REQ-014 fail_addr  output  ADDR_W  address of first mismatch.
REQ-015 err_count  output  8  saturating mismatch count.

Function
REQ-016 FSM states SHALL be IDLE, WR0, RD0, WR1, RD1, FIN.
REQ-017 Pattern: P0(a) = BASE XOR zero-extended/truncated a; P1(a) = ~P0(a).
REQ-018 IDLE/FIN with start=1 -> WR0 next cycle, clearing done, pass=1, fail_addr=0, err_count=0; start in any other state SHALL be ignored.
REQ-019 WR0/WR1: one cycle per address a = 0..N-1 ascending, SEL=1, Addr=a, Din=P0(a)/P1(a); then RD0/RD1.
REQ-020 RD0/RD1: N+1 cycles; cycle i<N drives SEL=0, Addr=i; cycle i>=1 compares Dout to pattern of address i-1.
REQ-021 RD0 -> WR1 and RD1 -> FIN after cycle N.
REQ-022 On mismatch: pass<=0, err_count increments (saturates at 255), fail_addr loads only on first mismatch of the run.
REQ-023 busy=1 exactly 4N+2 cycles (18 at defaults), starting the cycle after start is sampled; done=1 in FIN.
REQ-024 SEL SHALL be 0 in every state other than WR0/WR1; in IDLE and FIN, Addr=0 and Din=0.

Reset
REQ-025 reset=1 at a clock edge SHALL force IDLE with SEL, Addr, Din, busy, done, pass, fail_addr, err_count all 0, including mid-run.
REQ-026 reset SHALL take priority over start in the same cycle.

Configuration
REQ-027 With BIST_ERR_COUNT_EN defined, the err_count counter SHALL be implemented per REQ-022.
REQ-028 Without BIST_ERR_COUNT_EN, the err_count port SHALL remain and be tied to 0; pass and fail_addr are unaffected.

Structure
REQ-029 Package ram_bist_pkg SHALL hold ADDR_W, DATA_W and BASE defaults and the FSM state enum.
REQ-030 Combinational sub-module bist_pattern_gen (inputs addr, phase; output pattern) SHALL implement REQ-017; it is instantiated once for writes and once for the delayed compare.

Verification (defaults, BASE=A; P0 = A,B,8,9; P1 = 5,4,7,6)
REQ-031 Fault-free RAM model, start pulse -> busy 18 cycles, then done=1, pass=1, err_count=0, fail_addr=0.
REQ-032 Bit0 of word 2 stuck at 0 -> P0 read 8 passes; P1 read 6 vs 7 fails -> pass=0, fail_addr=2, err_count=1.
REQ-033 Model ignores Addr[1] (2 aliases 0, 3 aliases 1) -> mismatches at addresses 0 and 1 in both phases -> fail_addr=0, err_count=4 (0 when macro is off).
REQ-034 start re-pulsed at busy cycle 3 -> ignored, run still ends after 18 cycles; reset at busy cycle 5 -> next cycle all outputs 0, state IDLE; a new start gives a full 18-cycle run.
REQ-035 Bus trace -> SEL=1 on cycles 1-4 (Addr 0-3, Din A,B,8,9) and 10-13 (Din 5,4,7,6), SEL=0 on all other cycles.
